// File: rtl/tag_rtr_tm_reader_pkg.sv
// ---------------------------------------------------------------------------
// tag_rtr_tm_reader_pkg
// Shared definitions for the tag/RTR telemetry reader: FSM state encoding,
// frame geometry, the default sync pattern, and the frame-building helpers.
// Frame layout (first bit sent on the left):
//   SYNC_WORD[2:0], TAGR8..TAGR1, RTR5..RTR1, odd parity over the 13 data bits.
// ---------------------------------------------------------------------------
package tag_rtr_tm_reader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        DATA = 3'd2,
        PAR  = 3'd3,
        DONE = 3'd4
    } tm_state_e;

    localparam int SYNC_LEN  = 3;
    localparam int TAG_LEN   = 8;
    localparam int RTR_LEN   = 5;
    localparam int DATA_LEN  = TAG_LEN + RTR_LEN;
    localparam int FRAME_LEN = SYNC_LEN + DATA_LEN + 1;

    localparam logic [SYNC_LEN-1:0] DEF_SYNC_WORD = 3'b110;

    // Odd parity: the parity bit makes the total count of ones odd,
    // so an all-zero payload yields a 1.
    function automatic logic odd_parity(input logic [DATA_LEN-1:0] d);
        return ~^d;
    endfunction

    // Shift-register image of one frame; bit FRAME_LEN-1 goes out first.
    function automatic logic [FRAME_LEN-1:0] build_frame(
        input logic [SYNC_LEN-1:0] sync_word,
        input logic [TAG_LEN-1:0]  tagr,
        input logic [RTR_LEN-1:0]  rtr
    );
        return {sync_word, tagr, rtr, odd_parity({tagr, rtr})};
    endfunction

endpackage

// File: rtl/tag_rtr_tm_reader_tm_bit_timer.sv
// ---------------------------------------------------------------------------
// tm_bit_timer
// Divider that stretches each serial bit over BIT_DIV clock cycles.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   run      in   high while a frame bit is being sent
//   bit_end  out  last cycle of the current bit (combinational from the counter)
//   stb_next out  the coming cycle is the first cycle of a bit
// The counter sits at 0 whenever run is low, so the first bit of every frame
// starts with a fresh count.
// ---------------------------------------------------------------------------
module tm_bit_timer #(
    parameter int BIT_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_end,
    output logic stb_next
);

    localparam logic [7:0] LAST_CNT = 8'(BIT_DIV - 1);

    logic [7:0] div_q;
    logic [7:0] div_d;

    always_comb begin
        bit_end  = run && (div_q == LAST_CNT);
        div_d    = (run && !bit_end) ? div_q + 8'd1 : 8'd0;
        stb_next = (div_d == 8'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= 8'd0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/tag_rtr_tm_reader.sv
// ---------------------------------------------------------------------------
// tag_rtr_tm_reader
// Snapshots the tag (TAGR1-8) and real-time (RTR1-5) registers on request,
// sends them as a 17-bit framed serial stream (sync, data, odd parity) to the
// PCM telemetry multiplexer, then pulses the register-clear strobes.
// Ports:
//   SIM_CLK     in   system clock
//   SIM_RST     in   synchronous active-high reset
//   TAGR[7:0]   in   tag registers, bit 0 = TAGR1
//   RTR[4:0]    in   real-time registers, bit 0 = RTR1
//   RD_REQ      in   read request, level sampled
//   RD_BUSY     out  capture through the DONE cycle
//   RD_DONE     out  one-cycle end-of-frame pulse
//   TM_GATE     out  a frame bit is on TM_DATA
//   TM_DATA     out  serial data, 0 outside the gate
//   TM_BIT_STB  out  first cycle of each bit
//   TAG_CLR     out  one-cycle clear to the tag registers
//   RTR_CLR     out  one-cycle clear to the RTR registers
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module tag_rtr_tm_reader
    import tag_rtr_tm_reader_pkg::*;
#(
    parameter int                  BIT_DIV   = 4,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD = DEF_SYNC_WORD
) (
    input  logic               SIM_CLK,
    input  logic               SIM_RST,
    input  logic [TAG_LEN-1:0] TAGR,
    input  logic [RTR_LEN-1:0] RTR,
    input  logic               RD_REQ,
    output logic               RD_BUSY,
    output logic               RD_DONE,
    output logic               TM_GATE,
    output logic               TM_DATA,
    output logic               TM_BIT_STB,
    output logic               TAG_CLR,
    output logic               RTR_CLR
);

    localparam logic [4:0] LAST_SYNC_BIT = 5'(SYNC_LEN - 1);
    localparam logic [4:0] LAST_DATA_BIT = 5'(SYNC_LEN + DATA_LEN - 1);
    localparam logic [4:0] LAST_BIT      = 5'(FRAME_LEN - 1);

    tm_state_e              state_q, state_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [FRAME_LEN-1:0]   shift_q, shift_d;   // doubles as the frame shadow
    logic                   pend_q, pend_d;
    logic                   capture;

    logic busy_q, busy_d, done_q, done_d, gate_q, gate_d, data_q, data_d;
    logic stb_q, stb_d, tclr_q, tclr_d, rclr_q, rclr_d;

    logic run, bit_end, stb_next;

    assign run = (state_q == SYNC) || (state_q == DATA) || (state_q == PAR);

    tm_bit_timer #(.BIT_DIV(BIT_DIV)) u_timer (
        .clk      (SIM_CLK),
        .rst      (SIM_RST),
        .run      (run),
        .bit_end  (bit_end),
        .stb_next (stb_next)
    );

    // State register
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            pend_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            gate_q    <= 1'b0;
            data_q    <= 1'b0;
            stb_q     <= 1'b0;
            tclr_q    <= 1'b0;
            rclr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            gate_q    <= gate_d;
            data_q    <= data_d;
            stb_q     <= stb_d;
            tclr_q    <= tclr_d;
            rclr_q    <= rclr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pend_d    = pend_q;
        capture   = 1'b0;

        case (state_q)
            IDLE: if (RD_REQ) capture = 1'b1;
            SYNC: if (bit_end && bit_cnt_q == LAST_SYNC_BIT) state_d = DATA;
            DATA: if (bit_end && bit_cnt_q == LAST_DATA_BIT) state_d = PAR;
            PAR:  if (bit_end) state_d = DONE;
            // A request seen in the DONE cycle itself counts as pending, so a
            // held RD_REQ chains frames with a single DONE cycle between them.
            DONE: if (pend_q || RD_REQ) capture = 1'b1;
                  else state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // One-deep pending flag; re-asserting while already set is a no-op.
        if (run && RD_REQ) pend_d = 1'b1;

        if (bit_end) begin
            bit_cnt_d = (bit_cnt_q == LAST_BIT) ? 5'd0 : bit_cnt_q + 5'd1;
            shift_d   = {shift_q[FRAME_LEN-2:0], 1'b0};
        end

        if (capture) begin
            state_d   = SYNC;
            bit_cnt_d = 5'd0;
            shift_d   = build_frame(SYNC_WORD, TAGR, RTR);
            pend_d    = 1'b0;
        end
    end

    // Output logic, computed from the next state so the ports are registered
    always_comb begin
        gate_d = (state_d == SYNC) || (state_d == DATA) || (state_d == PAR);
        data_d = gate_d && shift_d[FRAME_LEN-1];
        stb_d  = gate_d && stb_next;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        tclr_d = (state_d == DONE);
        rclr_d = (state_d == DONE);
    end

    assign RD_BUSY    = busy_q;
    assign RD_DONE    = done_q;
    assign TM_GATE    = gate_q;
    assign TM_DATA    = data_q;
    assign TM_BIT_STB = stb_q;
    assign TAG_CLR    = tclr_q;
    assign RTR_CLR    = rclr_q;

endmodule

// File: tb/tb_tag_rtr_tm_reader.sv
// ---------------------------------------------------------------------------
// tb_tag_rtr_tm_reader
// Two instances share stimulus: u4 (BIT_DIV=4) for single-frame scenarios and
// u2 (BIT_DIV=2) for the held-request back-to-back scenario. Expected frames
// come from a bit-position model of the frame format with parity from a
// ones count.
// ---------------------------------------------------------------------------
module tb_tag_rtr_tm_reader;

    localparam int BD4 = 4;
    localparam int BD2 = 2;
    localparam int FRAME_BITS = 17;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tagr = 8'h00;
    logic [4:0] rtr = 5'h00;
    logic       rd_req = 1'b0;

    logic o4_busy, o4_done, o4_gate, o4_data, o4_stb, o4_tclr, o4_rclr;
    logic o2_busy, o2_done, o2_gate, o2_data, o2_stb, o2_tclr, o2_rclr;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tag_rtr_tm_reader #(.BIT_DIV(BD4)) u4 (
        .SIM_CLK(clk), .SIM_RST(rst), .TAGR(tagr), .RTR(rtr), .RD_REQ(rd_req),
        .RD_BUSY(o4_busy), .RD_DONE(o4_done), .TM_GATE(o4_gate), .TM_DATA(o4_data),
        .TM_BIT_STB(o4_stb), .TAG_CLR(o4_tclr), .RTR_CLR(o4_rclr)
    );

    tag_rtr_tm_reader #(.BIT_DIV(BD2)) u2 (
        .SIM_CLK(clk), .SIM_RST(rst), .TAGR(tagr), .RTR(rtr), .RD_REQ(rd_req),
        .RD_BUSY(o2_busy), .RD_DONE(o2_done), .TM_GATE(o2_gate), .TM_DATA(o2_data),
        .TM_BIT_STB(o2_stb), .TAG_CLR(o2_tclr), .RTR_CLR(o2_rclr)
    );

    // Reference: frame bit i (0 = first on the wire).
    function automatic logic exp_bit(input logic [7:0] t, input logic [4:0] r, input int i);
        logic [2:0] sync_w;
        int ones;
        sync_w = 3'b110;
        ones = 0;
        if (i < 3)  return sync_w[2-i];
        if (i < 11) return t[10-i];          // TAGR8 first
        if (i < 16) return r[15-i];          // RTR5 first
        for (int k = 0; k < 8; k++) ones += int'(t[k]);
        for (int k = 0; k < 5; k++) ones += int'(r[k]);
        return (ones % 2 == 0);              // make the total odd
    endfunction

    // Issue a one-cycle request; returns just after the capture edge.
    task automatic send_req(input logic [7:0] t, input logic [4:0] r);
        @(posedge clk);
        #1 rd_req = 1'b1; tagr = t; rtr = r;
        @(posedge clk);
        #1 rd_req = 1'b0;
    endtask

    // Called just after the capture edge; checks all 17 bits then the DONE cycle.
    task automatic check_frame(input logic [7:0] t, input logic [4:0] r, input string nm);
        for (int b = 0; b < FRAME_BITS; b++) begin
            logic e;
            int bad;
            logic [6:0] seen;
            e = exp_bit(t, r, b);
            bad = 0;
            seen = '0;
            for (int c = 0; c < BD4; c++) begin
                @(negedge clk);
                if (o4_gate !== 1'b1 || o4_data !== e || o4_stb !== (c == 0) ||
                    o4_busy !== 1'b1 || o4_done !== 1'b0 || o4_tclr !== 1'b0 || o4_rclr !== 1'b0) begin
                    bad++;
                    seen = {o4_gate, o4_data, o4_stb, o4_busy, o4_done, o4_tclr, o4_rclr};
                end
            end
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL %s bit%0d: gate,data,stb,busy,done,tclr,rclr=%b in %0d cycles, required data=%b for %0d cycles with stb on first",
                         nm, b, seen, bad, e, BD4);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({o4_gate, o4_data, o4_stb, o4_busy, o4_done, o4_tclr, o4_rclr} !== 7'b0001111) begin
            n_fail++;
            $display("FAIL %s done_cycle: gate,data,stb,busy,done,tclr,rclr=%b required 0001111",
                     nm, {o4_gate, o4_data, o4_stb, o4_busy, o4_done, o4_tclr, o4_rclr});
        end
    endtask

    task automatic check_idle(input int n, input string nm);
        int bad;
        logic [6:0] seen;
        bad = 0;
        seen = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if ({o4_gate, o4_data, o4_stb, o4_busy, o4_done, o4_tclr, o4_rclr} !== 7'b0) begin
                bad++;
                seen = {o4_gate, o4_data, o4_stb, o4_busy, o4_done, o4_tclr, o4_rclr};
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s idle: outputs=%b in %0d of %0d cycles, required 0000000", nm, seen, bad, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rd_req = 1'b1;
        tagr = 8'($urandom);
        rtr = 5'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({o4_gate, o4_data, o4_stb, o4_busy, o4_done, o4_tclr, o4_rclr} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_u4: outputs=%b required 0000000",
                     {o4_gate, o4_data, o4_stb, o4_busy, o4_done, o4_tclr, o4_rclr});
        end
        n_checks++;
        if ({o2_gate, o2_data, o2_stb, o2_busy, o2_done, o2_tclr, o2_rclr} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_u2: outputs=%b required 0000000",
                     {o2_gate, o2_data, o2_stb, o2_busy, o2_done, o2_tclr, o2_rclr});
        end
        rd_req = 1'b0;
        rst = 1'b0;
        check_idle(6, "after_reset");
    endtask

    task automatic test_basic_frame();
        send_req(8'hA5, 5'h13);
        check_frame(8'hA5, 5'h13, "basic_A5_13");
        check_idle(8, "basic_after");
    endtask

    task automatic test_parity_edges();
        send_req(8'h00, 5'h00);
        check_frame(8'h00, 5'h00, "all_zero");
        send_req(8'hFF, 5'h1F);
        check_frame(8'hFF, 5'h1F, "all_ones");
        check_idle(4, "parity_after");
    endtask

    task automatic test_random_frames();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] t;
            logic [4:0] r;
            t = 8'($urandom);
            r = 5'($urandom);
            send_req(t, r);
            check_frame(t, r, $sformatf("rand%0d", i));
        end
        check_idle(4, "rand_after");
    endtask

    // Two requests in one frame -> one extra frame carrying the DONE-edge inputs.
    task automatic test_pending();
        logic [7:0] t1, t2, t3;
        logic [4:0] r1, r2, r3;
        t1 = 8'h3C; r1 = 5'h05;
        t2 = 8'hC3; r2 = 5'h1A;
        t3 = 8'($urandom); r3 = 5'($urandom);
        if (t3 == t2) t3 = ~t2;
        send_req(t1, r1);
        fork
            begin
                check_frame(t1, r1, "pend_first");
                check_frame(t3, r3, "pend_second");
                check_idle(3 * FRAME_BITS * BD4, "pend_no_third");
            end
            begin
                repeat (10) @(posedge clk);
                #1 rd_req = 1'b1; tagr = t2; rtr = r2;
                @(posedge clk);
                #1 rd_req = 1'b0;
                repeat (19) @(posedge clk);
                #1 rd_req = 1'b1;
                @(posedge clk);
                #1 rd_req = 1'b0;
                repeat (37) @(posedge clk);      // into the DONE cycle
                #1 tagr = t3; rtr = r3;
                @(posedge clk);
                #1 tagr = t2; rtr = r2;
            end
        join
    endtask

    task automatic test_midframe_change();
        fork
            begin
                send_req(8'h01, 5'h0A);
                check_frame(8'h01, 5'h0A, "midframe");
                check_idle(10, "midframe_after");
            end
            begin
                repeat (22) @(posedge clk);
                #1 tagr = 8'h80; rtr = 5'h15;
            end
        join
    endtask

    task automatic test_reset_midframe();
        send_req(8'h5A, 5'h0F);
        repeat (4) @(posedge clk);
        #1 rd_req = 1'b1;                    // sets pending
        @(posedge clk);
        #1 rd_req = 1'b0;
        repeat (32) @(posedge clk);          // inside bit 9
        #1 rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o4_gate !== 1'b1 || o4_busy !== 1'b1 || o4_data !== exp_bit(8'h5A, 5'h0F, 9)) begin
            n_fail++;
            $display("FAIL rst_mid_prior: gate=%b busy=%b data=%b required 1 1 %b",
                     o4_gate, o4_busy, o4_data, exp_bit(8'h5A, 5'h0F, 9));
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({o4_gate, o4_data, o4_stb, o4_busy, o4_done, o4_tclr, o4_rclr} !== 7'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: outputs=%b required 0000000",
                     {o4_gate, o4_data, o4_stb, o4_busy, o4_done, o4_tclr, o4_rclr});
        end
        rst = 1'b0;
        check_idle(2 * FRAME_BITS * BD4, "rst_mid_no_restart");
    endtask

    // Held request on the BIT_DIV=2 instance: 35-cycle frame period.
    task automatic test_back_to_back();
        localparam int PERIOD = FRAME_BITS * BD2 + 1;
        localparam int NFR = 4;
        logic gate_h[NFR*PERIOD];
        logic stb_h[NFR*PERIOD];
        logic data_h[NFR*PERIOD];
        logic done_h[NFR*PERIOD];
        logic [7:0] t;
        logic [4:0] r;
        int waited;
        t = 8'($urandom);
        r = 5'($urandom);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; tagr = t; rtr = r; rd_req = 1'b1;
        @(posedge clk);                      // first capture edge
        for (int k = 0; k < NFR * PERIOD; k++) begin
            @(negedge clk);
            gate_h[k] = o2_gate;
            stb_h[k]  = o2_stb;
            data_h[k] = o2_data;
            done_h[k] = o2_done;
        end
        for (int f = 0; f < NFR; f++) begin
            int hi, nstb, dbad, s;
            s = f * PERIOD;
            hi = 0; nstb = 0; dbad = 0;
            for (int k = 0; k < PERIOD - 1; k++) begin
                if (gate_h[s+k] === 1'b1) hi++;
                if (stb_h[s+k] === 1'b1) begin
                    if (data_h[s+k] !== exp_bit(t, r, nstb)) dbad++;
                    nstb++;
                end
            end
            n_checks++;
            if (hi != PERIOD - 1 || gate_h[s+PERIOD-1] !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_gate f%0d: gate high %0d cycles, gap gate=%b, required %0d high then 0",
                         f, hi, gate_h[s+PERIOD-1], PERIOD - 1);
            end
            n_checks++;
            if (nstb != FRAME_BITS) begin
                n_fail++;
                $display("FAIL b2b_stb f%0d: %0d strobes required %0d", f, nstb, FRAME_BITS);
            end
            n_checks++;
            if (dbad != 0) begin
                n_fail++;
                $display("FAIL b2b_data f%0d: %0d wrong bits required 0", f, dbad);
            end
            n_checks++;
            if (done_h[s+PERIOD-1] !== 1'b1 || done_h[s+PERIOD-2] !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_done f%0d: done at gap=%b before=%b required 1 0",
                         f, done_h[s+PERIOD-1], done_h[s+PERIOD-2]);
            end
        end
        rd_req = 1'b0;
        waited = 0;
        while (o2_busy !== 1'b0 && waited < 3 * PERIOD) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (o2_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: busy=%b after %0d cycles required 0", o2_busy, waited);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_parity_edges();
        test_random_frames();
        test_pending();
        test_midframe_change();
        test_reset_midframe();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
